// File: rtl/aes_mix_columns_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_mix_columns_seq_if
//  Description : Handshake bundle for the iterative MixColumns engine.
//                Input side : in_valid/in_ready carrying in_state, in_inv,
//                             in_bypass.
//                Output side: out_valid/out_ready carrying out_state.
//                Status     : busy.
//                master = producer/consumer side, slave = engine side.
//  Revision    : 1.0  initial release
// ============================================================================
interface aes_mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_inv;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport master (
    output in_valid, in_state, in_inv, in_bypass, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_inv, in_bypass, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface
`default_nettype wire

// File: rtl/aes_mix_columns_seq.sv
`default_nettype none
// ============================================================================
//  Module      : aes_mix_columns_seq
//  Description : Iterative AES MixColumns / InvMixColumns engine.
//                Accepts a 128-bit state, rewrites COLS_PER_CYCLE columns
//                per clock in place, then presents the result until the
//                downstream handshake. Bypass mode returns the state as-is.
//  Ports       : clk        rising-edge clock
//                rst        asynchronous active-high reset
//                bus.slave  in_valid/in_ready/in_state/in_inv/in_bypass,
//                           out_valid/out_ready/out_state, busy
//  Parameters  : COLS_PER_CYCLE  1, 2 or 4 columns per clock
//  Revision    : 1.0  initial release
// ============================================================================
module aes_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_mix_columns_seq_if.slave   bus
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] CPC_STEP = 3'(COLS_PER_CYCLE);

  state_t       state_q,     state_d;
  logic [1:0]   cnt_q,       cnt_d;
  logic [127:0] data_q,      data_d;
  logic         inv_q,       inv_d;
  logic         in_ready_q,  in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q,      busy_d;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of MixColumns (inv=0) or InvMixColumns (inv=1). Row 0 sits in
  // the most significant byte. The 09/0b/0d/0e products are assembled from
  // the x2/x4/x8 chain so no multiplier tables are needed.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if (!inv) begin
        res[31-8*i -: 8] = x2[i]
                         ^ (x2[(i+1)%4] ^ a[(i+1)%4])
                         ^ a[(i+2)%4]
                         ^ a[(i+3)%4];
      end else begin
        res[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                         ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                         ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                         ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
      end
    end
    return res;
  endfunction

  // Counter advance computed one bit wider so that reaching column 4 (done)
  // is visible even when COLS_PER_CYCLE = 4.
  logic [2:0] cnt_sum;
  assign cnt_sum = {1'b0, cnt_q} + CPC_STEP;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    inv_d       = inv_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          data_d     = bus.in_state;
          inv_d      = bus.in_inv;
          cnt_d      = 2'd0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          if (bus.in_bypass) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d     = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        // Columns not selected this cycle keep their latched value.
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          logic [1:0] idx;
          idx = cnt_q + 2'(j);
          data_d[32*(3-int'(idx)) +: 32] = mix_col(data_q[32*(3-int'(idx)) +: 32], inv_q);
        end
        cnt_d = cnt_sum[1:0];
        if (cnt_sum[2]) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cnt_d       = 2'd0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      data_q      <= '0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      inv_q       <= inv_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Result is only ever taken from the state register.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = data_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_mix_columns_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_mix_columns_seq
//  Description : Directed bench for aes_mix_columns_seq. Three engines
//                (1, 2 and 4 columns per cycle) share one stimulus stream;
//                each result and latency is compared with hand-computed
//                values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_mix_columns_seq;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_state;
  logic         in_inv;
  logic         in_bypass;
  logic         out_ready;

  int checks;
  int errors;

  aes_mix_columns_seq_if bus1 ();
  aes_mix_columns_seq_if bus2 ();
  aes_mix_columns_seq_if bus4 ();

  assign bus1.in_valid  = in_valid;
  assign bus1.in_state  = in_state;
  assign bus1.in_inv    = in_inv;
  assign bus1.in_bypass = in_bypass;
  assign bus1.out_ready = out_ready;
  assign bus2.in_valid  = in_valid;
  assign bus2.in_state  = in_state;
  assign bus2.in_inv    = in_inv;
  assign bus2.in_bypass = in_bypass;
  assign bus2.out_ready = out_ready;
  assign bus4.in_valid  = in_valid;
  assign bus4.in_state  = in_state;
  assign bus4.in_inv    = in_inv;
  assign bus4.in_bypass = in_bypass;
  assign bus4.out_ready = out_ready;

  aes_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  aes_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  aes_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // Index 0/1/2 = CPC 1/2/4.
  logic [2:0]   ov, ir, bz;
  logic [127:0] os [3];
  assign ov = {bus4.out_valid, bus2.out_valid, bus1.out_valid};
  assign ir = {bus4.in_ready,  bus2.in_ready,  bus1.in_ready};
  assign bz = {bus4.busy,      bus2.busy,      bus1.busy};
  assign os[0] = bus1.out_state;
  assign os[1] = bus2.out_state;
  assign os[2] = bus4.out_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Run one operation on all three engines. Latency is counted in clock
  // edges after the accept edge; a bypass result is registered by the accept
  // edge itself, so it reads 0 here.
  task automatic run_op(input logic [127:0] st, input logic inv, input logic byp,
                        input logic tog, input logic [127:0] exp, input int hold);
    int lat [3];
    logic [127:0] snap [3];
    @(negedge clk);
    chk("in_ready_before_accept", 128'(ir), 128'(3'b111));
    in_state  = st;
    in_inv    = inv;
    in_bypass = byp;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (tog) begin
      in_inv    = ~inv;
      in_bypass = ~byp;
    end
    lat = '{-1, -1, -1};
    for (int k = 0; k <= 8; k++) begin
      for (int i = 0; i < 3; i++) if (ov[i] && lat[i] < 0) lat[i] = k;
      chk("in_ready_while_busy", 128'(ir), 128'(3'b000));
      chk("busy_while_busy", 128'(bz), 128'(3'b111));
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("latency_cpc%0d", 1 << i), 128'(lat[i]), byp ? 128'(0) : 128'(4 >> i));
      chk($sformatf("result_cpc%0d", 1 << i), os[i], exp);
      snap[i] = os[i];
    end
    repeat (hold) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) chk($sformatf("hold_state_cpc%0d", 1 << i), os[i], snap[i]);
      chk("hold_out_valid", 128'(ov), 128'(3'b111));
      chk("hold_in_ready", 128'(ir), 128'(3'b000));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_inv    = 1'b0;
    in_bypass = 1'b0;
    chk("out_valid_after_handshake", 128'(ov), 128'(3'b000));
    chk("in_ready_after_handshake", 128'(ir), 128'(3'b111));
  endtask

  typedef struct {
    logic [127:0] st;
    logic         inv;
    logic         byp;
    logic         tog;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] APPB_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] APPB_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

  vec_t vecs [8];

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    in_inv    = 1'b0;
    in_bypass = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{APPB_IN, 1'b0, 1'b0, 1'b0, APPB_OUT};
    vecs[1] = '{APPB_OUT, 1'b1, 1'b0, 1'b0, APPB_IN};
    vecs[2] = '{128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 1'b0, 1'b0,
                128'h8e4da1bc9fdc589d01010101c6c6c6c6};
    vecs[3] = '{128'h8e4da1bc9fdc589d01010101c6c6c6c6, 1'b1, 1'b0, 1'b0,
                128'hdb135345f20a225c01010101c6c6c6c6};
    vecs[4] = '{128'hd4d4d4d52d26314c01010101c6c6c6c6, 1'b0, 1'b0, 1'b0,
                128'hd5d5d7d64d7ebdf801010101c6c6c6c6};
    vecs[5] = '{128'h00112233445566778899aabbccddeeff, 1'b1, 1'b1, 1'b1,
                128'h00112233445566778899aabbccddeeff};
    vecs[6] = '{APPB_IN, 1'b0, 1'b0, 1'b1, APPB_OUT};
    vecs[7] = '{APPB_OUT, 1'b1, 1'b0, 1'b1, APPB_IN};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 128'(ov), 128'(3'b000));
    chk("reset_in_ready", 128'(ir), 128'(3'b111));
    chk("reset_busy", 128'(bz), 128'(3'b000));
    for (int i = 0; i < 3; i++) chk($sformatf("reset_out_state_cpc%0d", 1 << i), os[i], 128'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_op(vecs[v].st, vecs[v].inv, vecs[v].byp, vecs[v].tog, vecs[v].exp, 0);
    end

    // Backpressure for 10 cycles, then an immediate back-to-back accept.
    run_op(vecs[2].st, 1'b0, 1'b0, 1'b0, vecs[2].exp, 10);
    run_op(APPB_IN, 1'b0, 1'b0, 1'b0, APPB_OUT, 0);

    // Asynchronous reset after two columns of the CPC=1 engine.
    @(negedge clk);
    in_state  = APPB_IN;
    in_inv    = 1'b0;
    in_bypass = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 128'(ov), 128'(3'b000));
    chk("async_rst_in_ready", 128'(ir), 128'(3'b111));
    chk("async_rst_busy", 128'(bz), 128'(3'b000));
    for (int i = 0; i < 3; i++) chk($sformatf("async_rst_out_state_cpc%0d", 1 << i), os[i], 128'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(APPB_OUT, 1'b1, 1'b0, 1'b0, APPB_IN, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
